// File: rtl/dht11_pkg.sv
// dht11_pkg: state encoding, protocol timing and checksum helper shared by
// the DHT11 responder and the DHT11 host controller.
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_RESP_DELAY,
        ST_ACK_LOW,
        ST_ACK_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht11_state_e;

    localparam int ACK_LOW_US   = 80;
    localparam int ACK_HIGH_US  = 80;
    localparam int BIT_LOW_US   = 50;
    localparam int BIT0_HIGH_US = 26;
    localparam int BIT1_HIGH_US = 70;
    localparam int END_LOW_US   = 50;
    localparam int FRAME_BITS   = 40;
    localparam int US_CNT_W     = 15;

    function automatic logic [7:0] dht11_checksum(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic [7:0] d
    );
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: restartable microsecond prescaler; the restart cycle
// counts as the first clock of the new microsecond.
module dht11_us_tick #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_pos;

    assign w_pos = restart ? '0 : r_cnt;
    assign tick  = (w_pos == PW'(CLKS_PER_US - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_pos + PW'(1);
        end
    end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator driving ack + 40-bit frame.
// Optional DHT11_RESP_CRC_ERR_EN adds crc_corrupt to invert the checksum.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLKS_PER_US   = 50,
    parameter int START_MIN_US  = 10000,
    parameter int RESP_DELAY_US = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dht_in,
    output logic       dht_drive_low,
    input  logic [7:0] humi_int,
    input  logic [7:0] humi_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_CRC_ERR_EN
    input  logic       crc_corrupt,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic       bus_err
);

    dht11_state_e        r_state;
    logic                r_sync1;
    logic                r_din_s;
    logic                r_restart;
    logic [1:0]          r_age;
    logic [US_CNT_W-1:0] r_us;
    logic [5:0]          r_bit;
    logic [39:0]         r_shift;
    logic                r_drive;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_tick;
    logic [1:0]          w_age;
    logic                w_settled;
    logic [US_CNT_W-1:0] w_us;
    logic [US_CNT_W-1:0] w_len;
    logic                w_done;
    logic                w_collide;
    logic [7:0]          w_chk;

    dht11_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (r_restart),
        .tick    (w_tick)
    );

    assign w_us      = r_restart ? '0 : r_us;
    assign w_age     = r_restart ? '0 : r_age;
    // the first two cycles of a state still see the old bus level
    assign w_settled = (w_age == 2'd2);
    assign w_done    = w_tick && (w_us == w_len - 15'd1);
    assign w_collide = w_settled && !r_din_s;

`ifdef DHT11_RESP_CRC_ERR_EN
    assign w_chk = dht11_checksum(humi_int, humi_dec, temp_int, temp_dec)
                 ^ {8{crc_corrupt}};
`else
    assign w_chk = dht11_checksum(humi_int, humi_dec, temp_int, temp_dec);
`endif

    always_comb begin
        w_len = 15'd1;
        unique case (r_state)
            ST_RESP_DELAY: w_len = 15'(RESP_DELAY_US);
            ST_ACK_LOW:    w_len = 15'(ACK_LOW_US);
            ST_ACK_HIGH:   w_len = 15'(ACK_HIGH_US);
            ST_BIT_LOW:    w_len = 15'(BIT_LOW_US);
            ST_BIT_HIGH:   w_len = r_shift[39] ? 15'(BIT1_HIGH_US)
                                               : 15'(BIT0_HIGH_US);
            ST_END_LOW:    w_len = 15'(END_LOW_US);
            default:       w_len = 15'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_din_s <= 1'b1;
            r_age   <= '0;
            r_us    <= '0;
        end else begin
            r_sync1 <= dht_in;
            r_din_s <= r_sync1;
            r_age   <= w_settled ? 2'd2 : w_age + 2'd1;
            if (w_tick && w_us != '1) r_us <= w_us + 15'd1;
            else                      r_us <= w_us;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_restart <= 1'b0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_drive   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_restart <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_drive <= 1'b0;
                    if (w_settled && !r_din_s) begin
                        r_state   <= ST_HOST_LOW;
                        r_restart <= 1'b1;
                    end
                end
                ST_HOST_LOW: begin
                    if (r_din_s) begin
                        r_restart <= 1'b1;
                        if (w_us >= 15'(START_MIN_US)) begin
                            r_shift <= {humi_int, humi_dec,
                                        temp_int, temp_dec, w_chk};
                            r_bit   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_RESP_DELAY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RESP_DELAY: begin
                    if (w_done) begin
                        r_state   <= ST_ACK_LOW;
                        r_restart <= 1'b1;
                        r_drive   <= 1'b1;
                    end
                end
                ST_ACK_LOW: begin
                    if (w_done) begin
                        r_state   <= ST_ACK_HIGH;
                        r_restart <= 1'b1;
                        r_drive   <= 1'b0;
                    end
                end
                ST_ACK_HIGH, ST_BIT_HIGH: begin
                    if (w_collide) begin
                        r_state   <= ST_IDLE;
                        r_restart <= 1'b1;
                        r_drive   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_err     <= 1'b1;
                    end else if (w_done) begin
                        r_restart <= 1'b1;
                        r_drive   <= 1'b1;
                        if (r_state == ST_ACK_HIGH) begin
                            r_state <= ST_BIT_LOW;
                        end else begin
                            r_shift <= {r_shift[38:0], 1'b0};
                            if (r_bit == 6'(FRAME_BITS - 1)) begin
                                r_state <= ST_END_LOW;
                            end else begin
                                r_bit   <= r_bit + 6'd1;
                                r_state <= ST_BIT_LOW;
                            end
                        end
                    end
                end
                ST_BIT_LOW: begin
                    if (w_done) begin
                        r_state   <= ST_BIT_HIGH;
                        r_restart <= 1'b1;
                        r_drive   <= 1'b0;
                    end
                end
                ST_END_LOW: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_restart <= 1'b1;
                        r_drive   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_restart <= 1'b1;
                    r_drive   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dht_drive_low = r_drive;
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign bus_err       = r_err;

endmodule
